regfile_access_ctrl: RTL and testbench

//  Command-driven initiator for the 8x8 two-read/one-write register file.
//  - Accepts one command at a time over a valid/ready handshake.
//  - Sequences the file's combinational read port and edge-triggered write port.
//  - Returns the operands read or computed on a valid/ready response channel.
//  - Sits between the datapath sequencer and the register file; it is the only driver of the file's ports.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the 8x8 two-read/one-write register file and its
//   initiators: default widths, command opcodes and the access-controller
//   FSM state encoding.
package regfile_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_ADD   = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WSET = 3'd2,
        WPUL = 3'd3,
        RESP = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
//   Command-driven initiator for the two-read/one-write register file.
//   One command at a time is accepted on cmd_*, the file's combinational read
//   port and edge-triggered write port are sequenced, and the result is
//   returned on rsp_* and held until rsp_ready.
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_op/dst/src_a/src_b/wdata fields
//   rsp_valid/rsp_ready   response handshake; rsp_data_a/b, rsp_carry fields
//   rf_raddr1/2, rf_re    file read port; rf_rdata1/2 come back combinationally
//   rf_waddr/wdata, rf_we file write port; the file writes on rf_we rising
// Every output is a flop: the always_comb block computes the value each
// output takes in the next state, and the always_ff block registers it.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data_a,
    output logic [DATA_W-1:0] rsp_data_b,
    output logic              rsp_carry,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    output logic              rf_re,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we
);

    state_t            state, state_n;
    logic [1:0]        op_q, op_n;
    logic [ADDR_W-1:0] dst_q, dst_n;
    logic [ADDR_W-1:0] raddr1_n, raddr2_n, waddr_n;
    logic [DATA_W-1:0] wdata_n, rsp_a_n, rsp_b_n;
    logic              carry_n;
    logic [DATA_W:0]   sum;

    // Only consumed in RD, where rf_re=1 guarantees the read bus is driven.
    assign sum = {1'b0, rf_rdata1} + {1'b0, rf_rdata2};

    always_comb begin
        state_n  = state;
        op_n     = op_q;
        dst_n    = dst_q;
        raddr1_n = rf_raddr1;
        raddr2_n = rf_raddr2;
        waddr_n  = rf_waddr;
        wdata_n  = rf_wdata;
        rsp_a_n  = rsp_data_a;
        rsp_b_n  = rsp_data_b;
        carry_n  = rsp_carry;

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_n     = cmd_op;
                    dst_n    = cmd_dst;
                    raddr1_n = cmd_src_a;
                    raddr2_n = cmd_src_b;
                    if (cmd_op == OP_WRITE) begin
                        state_n = WSET;
                        waddr_n = cmd_dst;
                        wdata_n = cmd_wdata;
                        rsp_a_n = cmd_wdata;
                        rsp_b_n = '0;
                        carry_n = 1'b0;
                    end else begin
                        state_n = RD;
                    end
                end
            end
            RD: begin
                // Operands are captured here, before any write, so dst==src is safe.
                unique case (op_q)
                    OP_READ: begin
                        state_n = RESP;
                        rsp_a_n = rf_rdata1;
                        rsp_b_n = rf_rdata2;
                        carry_n = 1'b0;
                    end
                    OP_COPY: begin
                        state_n = WSET;
                        waddr_n = dst_q;
                        wdata_n = rf_rdata1;
                        rsp_a_n = rf_rdata1;
                        rsp_b_n = '0;
                        carry_n = 1'b0;
                    end
                    default: begin
                        state_n = WSET;
                        waddr_n = dst_q;
                        wdata_n = sum[DATA_W-1:0];
                        rsp_a_n = sum[DATA_W-1:0];
                        rsp_b_n = rf_rdata2;
                        carry_n = sum[DATA_W];
                    end
                endcase
            end
            WSET:    state_n = WPUL;
            WPUL:    state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= '0;
            dst_q      <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data_a <= '0;
            rsp_data_b <= '0;
            rsp_carry  <= 1'b0;
            rf_raddr1  <= '0;
            rf_raddr2  <= '0;
            rf_re      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rf_we      <= 1'b0;
        end else begin
            state      <= state_n;
            op_q       <= op_n;
            dst_q      <= dst_n;
            cmd_ready  <= (state_n == IDLE);
            rsp_valid  <= (state_n == RESP);
            rsp_data_a <= rsp_a_n;
            rsp_data_b <= rsp_b_n;
            rsp_carry  <= carry_n;
            rf_raddr1  <= raddr1_n;
            rf_raddr2  <= raddr2_n;
            rf_re      <= (state_n == RD);
            rf_waddr   <= waddr_n;
            rf_wdata   <= wdata_n;
            rf_we      <= (state_n == WPUL);
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl
//   Directed bench for regfile_access_ctrl together with a behavioural 8x8
//   register file (combinational reads, Z when rf_re=0; write on rf_we rising).
module tb_regfile_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_dst = 3'd0, cmd_src_a = 3'd0, cmd_src_b = 3'd0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data_a, rsp_data_b;
    logic       rsp_carry;
    logic [2:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic       rf_re, rf_we;
    logic [7:0] rf_wdata;
    wire  [7:0] rf_rdata1, rf_rdata2;

    logic [7:0] rf_mem [8] = '{default: 8'h00};

    int n_cmp = 0;
    int n_err = 0;
    int we_edges = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    always @(posedge rf_we) begin
        rf_mem[rf_waddr] <= rf_wdata;
        we_edges <= we_edges + 1;
    end

    assign rf_rdata1 = rf_re ? rf_mem[rf_raddr1] : 8'hzz;
    assign rf_rdata2 = rf_re ? rf_mem[rf_raddr2] : 8'hzz;

    always @(negedge clk) if (rf_re && rf_we) overlap <= overlap + 1;

    regfile_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b), .rsp_carry(rsp_carry),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_re(rf_re),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we)
    );

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command with rsp_ready=1; returns latency in sampling points
    // (falling edges after the accept edge) until rsp_valid, plus the response.
    task automatic issue(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] a,
                         input logic [2:0] b, input logic [7:0] wd, output int lat,
                         output logic [7:0] ra, output logic [7:0] rb, output logic rc);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk1("cmd_ready_before_issue", cmd_ready, 1'b1);
        cmd_op = op; cmd_dst = dst; cmd_src_a = a; cmd_src_b = b; cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        ra = rsp_data_a; rb = rsp_data_b; rc = rsp_carry;
        @(posedge clk);
        #1;
    endtask

    int         lat, e0, guard;
    logic [7:0] ra, rb;
    logic       rc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_rf_re", rf_re, 1'b0);
        chk1("rst_rf_we", rf_we, 1'b0);
        chk8("rst_rsp_data_a", rsp_data_a, 8'h00);
        @(negedge clk) rst_n = 1'b1;

        // 1. WRITE r3=A5, READ a=3 b=0
        issue(2'b00, 3'd3, 3'd0, 3'd0, 8'hA5, lat, ra, rb, rc);
        chkn("t1_write_latency", lat, 3);
        chk8("t1_write_echo", ra, 8'hA5);
        issue(2'b01, 3'd0, 3'd3, 3'd0, 8'h00, lat, ra, rb, rc);
        chkn("t1_read_latency", lat, 2);
        chk8("t1_read_a", ra, 8'hA5);
        chk8("t1_read_b", rb, 8'h00);

        // 2. ADD with carry
        issue(2'b00, 3'd1, 3'd0, 3'd0, 8'hF0, lat, ra, rb, rc);
        issue(2'b00, 3'd2, 3'd0, 3'd0, 8'h1F, lat, ra, rb, rc);
        issue(2'b11, 3'd4, 3'd1, 3'd2, 8'h00, lat, ra, rb, rc);
        chkn("t2_add_latency", lat, 4);
        chk8("t2_add_sum", ra, 8'h0F);
        chk8("t2_add_b", rb, 8'h1F);
        chk1("t2_add_carry", rc, 1'b1);
        issue(2'b01, 3'd0, 3'd4, 3'd1, 8'h00, lat, ra, rb, rc);
        chk8("t2_read_r4", ra, 8'h0F);
        chk1("t2_read_carry", rc, 1'b0);

        // 3. COPY self and COPY r1->r6, one rf_we edge each
        issue(2'b00, 3'd5, 3'd0, 3'd0, 8'h3C, lat, ra, rb, rc);
        e0 = we_edges;
        issue(2'b10, 3'd5, 3'd5, 3'd0, 8'h00, lat, ra, rb, rc);
        chkn("t3_copy_latency", lat, 4);
        chkn("t3_copy_self_edges", we_edges - e0, 1);
        chk8("t3_copy_self_val", ra, 8'h3C);
        e0 = we_edges;
        issue(2'b10, 3'd6, 3'd1, 3'd0, 8'h00, lat, ra, rb, rc);
        chkn("t3_copy_edges", we_edges - e0, 1);
        chk8("t3_copy_val", ra, 8'hF0);
        chk8("t3_copy_b", rb, 8'h00);
        issue(2'b01, 3'd0, 3'd5, 3'd6, 8'h00, lat, ra, rb, rc);
        chk8("t3_read_r5", ra, 8'h3C);
        chk8("t3_read_r6", rb, 8'hF0);

        // 4. Back-pressure on the response channel
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_op = 2'b01; cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!rsp_valid && guard < 20);
        chk1("t4_rsp_valid", rsp_valid, 1'b1);
        cmd_op = 2'b00; cmd_dst = 3'd0; cmd_wdata = 8'h77;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("t4_hold_valid", rsp_valid, 1'b1);
            chk8("t4_hold_a", rsp_data_a, 8'hF0);
            chk8("t4_hold_b", rsp_data_b, 8'h1F);
            chk1("t4_hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk1("t4_drained_valid", rsp_valid, 1'b0);
        chk1("t4_drained_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk1("t4_second_accepted", cmd_ready, 1'b0);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!rsp_valid && guard < 20);
        chkn("t4_second_latency", guard, 3);
        chk8("t4_second_echo", rsp_data_a, 8'h77);
        @(posedge clk);
        #1;

        // 5. Reset during WSET of a WRITE to r7
        e0 = we_edges;
        @(negedge clk);
        cmd_op = 2'b00; cmd_dst = 3'd7; cmd_wdata = 8'hEE;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk8("t5_in_wset_waddr", {5'b0, rf_waddr}, 8'h07);
        rst_n = 1'b0;
        #1;
        chk1("t5_rst_cmd_ready", cmd_ready, 1'b1);
        chk1("t5_rst_rsp_valid", rsp_valid, 1'b0);
        chk1("t5_rst_rf_we", rf_we, 1'b0);
        chk1("t5_rst_rf_re", rf_re, 1'b0);
        chk8("t5_rst_rf_wdata", rf_wdata, 8'h00);
        chk8("t5_rst_rf_waddr", {5'b0, rf_waddr}, 8'h00);
        chk8("t5_rst_rsp_a", rsp_data_a, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chkn("t5_no_we_edge", we_edges - e0, 0);
        issue(2'b01, 3'd0, 3'd7, 3'd0, 8'h00, lat, ra, rb, rc);
        chk8("t5_r7_unchanged", ra, 8'h00);
        chk8("t5_r0_written", rb, 8'h77);

        // 6. Back-to-back writes, then read pairs
        for (int i = 0; i < 8; i++)
            issue(2'b00, 3'(i), 3'd0, 3'd0, 8'h10 + 8'(i), lat, ra, rb, rc);
        for (int i = 0; i < 4; i++) begin
            issue(2'b01, 3'd0, 3'(i), 3'(7 - i), 8'h00, lat, ra, rb, rc);
            chk8("t6_pair_a", ra, 8'h10 + 8'(i));
            chk8("t6_pair_b", rb, 8'h17 - 8'(i));
        end
        chkn("t6_re_we_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
